axi_lite_initiator: RTL and testbench
=====================================

AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning response-wait cycles before abort (macro builds only), legal range 1..65535.
REQ-002 SHALL have port clk_i input 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_ni input 1, the reset: asynchronous, active-low.
REQ-004 SHALL have requester ports:
- req_i in 1, request
- we_i in 1, 1=write
- addr_i in 32
- wdata_i in 32
- be_i in 4, byte enables
- gnt_o out 1, request accepted
- rsp_valid_o out 1, response pulse
- rsp_rdata_o out 32
- rsp_err_o out 1
REQ-005 SHALL have AXI-Lite manager ports:
- m_axi_awaddr_o out 32, m_axi_awvalid_o out 1, m_axi_awready_i in 1
- m_axi_wdata_o out 32, m_axi_wstrb_o out 4, m_axi_wvalid_o out 1, m_axi_wready_i in 1
- m_axi_bresp_i in 2, m_axi_bvalid_i in 1, m_axi_bready_o out 1
- m_axi_araddr_o out 32, m_axi_arvalid_o out 1, m_axi_arready_i in 1
- m_axi_rdata_i in 32, m_axi_rresp_i in 2, m_axi_rvalid_i in 1, m_axi_rready_o out 1

Function
REQ-006 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; one transaction outstanding at a time.
REQ-007 gnt_o SHALL be combinational: req_i && state==IDLE; on that edge, addr/wdata/be/we SHALL be registered and the FSM SHALL go to WR_REQ (we_i=1) or RD_REQ.
REQ-008 In WR_REQ, awvalid and wvalid SHALL assert together the cycle after grant; each SHALL drop independently after its own ready handshake.
REQ-009 WR_REQ SHALL go to WR_RESP once both AW and W have handshaken, in the same cycle or in either order.
REQ-010 In RD_REQ, arvalid SHALL assert; after the arready handshake the FSM SHALL go to RD_RESP.
REQ-011 bready_o SHALL be 1 only in WR_RESP; rready_o SHALL be 1 only in RD_RESP, except as given in REQ-019.
REQ-012 Any valid SHALL NOT deassert, and its address/data/strobe SHALL NOT change, until the matching ready is seen.
REQ-013 On the B or R handshake, rsp_valid_o SHALL pulse for exactly one cycle on the next edge.
- rsp_err_o = (resp != OKAY).
- rsp_rdata_o = rdata_i for reads; 0 for writes.
- FSM SHALL return to IDLE on that same edge.
REQ-014 Zero-wait subordinate latency SHALL be:
- grant at cycle 0, valids at cycle 1, ready at cycle 1;
- bready/rready at cycle 2, response handshake at cycle 2;
- rsp_valid_o at cycle 3; next grant possible at cycle 3.
REQ-015 rsp_rdata_o and rsp_err_o SHALL hold their values until the next response.
REQ-016 req_i outside IDLE SHALL be ignored (gnt_o=0); the requester holds it.

Reset
REQ-017 Asserting rst_ni SHALL immediately force:
- state IDLE;
- all AXI valid/ready outputs 0;
- gnt_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0;
- AXI address/data/strobe outputs 0;
- watchdog count 0.
REQ-018 Reset mid-transaction SHALL abandon the transaction; no response pulse SHALL follow.

Configuration
REQ-019 With AXI_LITE_INITIATOR_TIMEOUT_EN defined:
- a counter SHALL count cycles in WR_RESP/RD_RESP;
- at TIMEOUT_CYCLES it SHALL issue rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=32'hDEAD_BEEF, and go to IDLE;
- bready_o and rready_o SHALL also be 1 in IDLE, draining late responses silently.
REQ-020 Without the macro, no counter SHALL exist and the module SHALL wait indefinitely in WR_RESP/RD_RESP.

Structure
REQ-021 Package axi_lite_initiator_pkg SHALL hold:
- state enum;
- RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
- TIMEOUT_RDATA=32'hDEAD_BEEF.
REQ-022 The watchdog SHALL be sub-module axi_lite_initiator_wdog (start, clear, expire), instantiated only under the macro.

Verification
REQ-023 Write addr 0x4, data 0xCAFE_F00D, be 0xF, zero-wait subordinate -> awaddr=0x4, wdata, wstrb=0xF; rsp_valid_o at cycle 3, err 0.
REQ-024 Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, single B, err 0.
REQ-025 Read addr 0x8, subordinate returns 0x1234_5678 with SLVERR after 2 wait cycles -> rsp_rdata_o=0x1234_5678, rsp_err_o=1.
REQ-026 req_i held high during a read -> gnt_o=0 until the rsp_valid_o cycle, then 1.
REQ-027 rst_ni low while awvalid=1 and awready=0 -> awvalid 0 immediately, state IDLE, no response pulse.
REQ-028 Macro defined, TIMEOUT_CYCLES=8, bvalid never asserted -> rsp_valid_o after 8 WR_RESP cycles with err=1 and rdata 0xDEAD_BEEF; a late bvalid is drained in IDLE.

Source files
------------

// File: rtl/axi_lite_initiator_pkg.sv
// Shared types and constants for the AXI-Lite initiator.
package axi_lite_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_EXOKAY   = 2'b01;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Anything other than OKAY is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_lite_initiator_wdog.sv
// Response watchdog: counts cycles while start_i is high, restarts from zero
// when clear_i is high, and flags expiry on the TIMEOUT_CYCLES-th counted cycle.
module axi_lite_initiator_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, otherwise advance while the wait is active.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (start_i) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = start_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI-Lite initiator bridging a simple req/gnt port.
// Optional response watchdog enabled by defining AXI_LITE_INITIATOR_TIMEOUT_EN.
module axi_lite_initiator
    import axi_lite_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        ar_valid_q, ar_valid_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        gnt_s;
    logic        wait_rsp_s;
    logic        wd_expire_s;
    logic        drain_idle_s;

    // Reset is folded in so gnt_o is low while rst_ni is held.
    assign gnt_s      = req_i && rst_ni && (state_q == ST_IDLE);
    assign wait_rsp_s = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    assign drain_idle_s = 1'b1;

    axi_lite_initiator_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (wait_rsp_s),
        .clear_i (!wait_rsp_s),
        .expire_o(wd_expire_s)
    );
`else
    assign drain_idle_s = 1'b0;
    assign wd_expire_s  = 1'b0;
`endif

    // Transaction FSM: next state, AXI channel valids and response capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s) begin
                    addr_d = addr_i;
                    if (we_i) begin
                        wdata_d    = wdata_i;
                        wstrb_d    = be_i;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = ST_WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (aw_valid_q && m_axi_awready_i) begin
                    aw_valid_d = 1'b0;
                end else begin
                    aw_valid_d = aw_valid_q;
                end
                if (w_valid_q && m_axi_wready_i) begin
                    w_valid_d = 1'b0;
                end else begin
                    w_valid_d = w_valid_q;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && m_axi_bvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = resp_is_err(m_axi_bresp_i);
                    state_d     = ST_IDLE;
                end else if (wd_expire_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = TIMEOUT_RDATA;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (ar_valid_q && m_axi_arready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (rready_q && m_axi_rvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata_i;
                    rsp_err_d   = resp_is_err(m_axi_rresp_i);
                    state_d     = ST_IDLE;
                end else if (wd_expire_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = TIMEOUT_RDATA;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                ar_valid_d = 1'b0;
            end
        endcase
        // Response readies follow the state being entered so they are registered.
        bready_d = (state_d == ST_WR_RESP) || (drain_idle_s && (state_d == ST_IDLE));
        rready_d = (state_d == ST_RD_RESP) || (drain_idle_s && (state_d == ST_IDLE));
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign gnt_o           = gnt_s;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_err_o       = rsp_err_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = aw_valid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = w_valid_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = ar_valid_q;
    assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Self-checking bench for axi_lite_initiator: directed and randomized
// transactions against a subordinate model; expectations come from the
// protocol rules (response cycle = handshake cycle + 1, err = resp != OKAY).
module tb_axi_lite_initiator;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
    logic [3:0]  be_i = 4'h0;
    logic        gnt_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] m_axi_awaddr_o, m_axi_wdata_o, m_axi_araddr_o;
    logic        m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o;
    logic [3:0]  m_axi_wstrb_o;
    logic        m_axi_awready_i = 1'b0, m_axi_wready_i = 1'b0, m_axi_bvalid_i = 1'b0;
    logic        m_axi_arready_i = 1'b0, m_axi_rvalid_i = 1'b0;
    logic [1:0]  m_axi_bresp_i = 2'b00, m_axi_rresp_i = 2'b00;
    logic [31:0] m_axi_rdata_i = 32'h0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_lite_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
        .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wvalid_o(m_axi_wvalid_o),
        .m_axi_wready_i(m_axi_wready_i),
        .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
        .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
        .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i), .m_axi_rvalid_i(m_axi_rvalid_i),
        .m_axi_rready_o(m_axi_rready_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_sub();
        m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0; m_axi_bvalid_i = 1'b0;
        m_axi_arready_i = 1'b0; m_axi_rvalid_i = 1'b0;
    endtask

    // One transaction. a_dly/w_dly: cycles after valids before the ready;
    // r_dly: cycles after entering the response wait before B/R valid.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int a_dly, input int w_dly,
                           input int r_dly, input logic [1:0] resp,
                           input logic [31:0] rd, input bit hold);
        bit a_done, w_done, r_done, got, resp_on;
        int t_resp, t_hs, k;
        a_done = 1'b0; w_done = !we; r_done = 1'b0; got = 1'b0;
        t_resp = -1; t_hs = -1;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
        #1 check_eq("gnt_idle", {31'h0, gnt_o}, 32'h1);
        @(negedge clk_i);
        if (!hold) req_i = 1'b0;
        for (k = 1; k < 64 && !got; k++) begin
            resp_on = !r_done && (t_resp >= 0) && (k >= t_resp + r_dly);
            m_axi_awready_i = we && !a_done && (k >= 1 + a_dly);
            m_axi_arready_i = !we && !a_done && (k >= 1 + a_dly);
            m_axi_wready_i  = we && !w_done && (k >= 1 + w_dly);
            m_axi_bvalid_i  = we && resp_on;
            m_axi_rvalid_i  = !we && resp_on;
            m_axi_bresp_i   = resp; m_axi_rresp_i = resp; m_axi_rdata_i = rd;
            #1;
            if (rsp_valid_o) begin
                got = 1'b1;
                if (r_done) begin
                    check_eq("rsp_cycle", k, t_hs + 1);
                    exp_err   = (resp != 2'b00);
                    exp_rdata = we ? 32'h0 : rd;
                end else begin
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
                    check_eq("tmo_cycle", k, t_resp + TMO);
                    exp_err   = 1'b1;
                    exp_rdata = 32'hDEAD_BEEF;
`else
                    check_eq("rsp_without_handshake", {31'h0, r_done}, 32'h1);
`endif
                end
                check_eq("rsp_err", {31'h0, rsp_err_o}, {31'h0, exp_err});
                check_eq("rsp_rdata", rsp_rdata_o, exp_rdata);
                if (hold) check_eq("gnt_at_rsp", {31'h0, gnt_o}, 32'h1);
                req_i = 1'b0;
            end else begin
                if (hold) check_eq("gnt_busy", {31'h0, gnt_o}, 32'h0);
                if (we) begin
                    check_eq("awvalid", {31'h0, m_axi_awvalid_o}, {31'h0, !a_done});
                    check_eq("wvalid", {31'h0, m_axi_wvalid_o}, {31'h0, !w_done});
                    if (!a_done) check_eq("awaddr", m_axi_awaddr_o, a);
                    if (!w_done) begin
                        check_eq("wdata", m_axi_wdata_o, d);
                        check_eq("wstrb", {28'h0, m_axi_wstrb_o}, {28'h0, be});
                    end
                    if (!r_done) check_eq("bready", {31'h0, m_axi_bready_o}, {31'h0, t_resp >= 0});
                end else begin
                    check_eq("arvalid", {31'h0, m_axi_arvalid_o}, {31'h0, !a_done});
                    if (!a_done) check_eq("araddr", m_axi_araddr_o, a);
                    if (!r_done) check_eq("rready", {31'h0, m_axi_rready_o}, {31'h0, t_resp >= 0});
                end
            end
            if (we && m_axi_awvalid_o && m_axi_awready_i) a_done = 1'b1;
            if (!we && m_axi_arvalid_o && m_axi_arready_i) a_done = 1'b1;
            if (we && m_axi_wvalid_o && m_axi_wready_i) w_done = 1'b1;
            if (resp_on && (we ? m_axi_bready_o : m_axi_rready_o)) begin
                r_done = 1'b1;
                t_hs = k;
            end
            if (t_resp < 0 && a_done && w_done) t_resp = k + 1;
            @(negedge clk_i);
        end
        idle_sub();
        req_i = 1'b0;
        check_eq("rsp_seen", {31'h0, got}, 32'h1);
        #1;
        check_eq("rsp_pulse_end", {31'h0, rsp_valid_o}, 32'h0);
        check_eq("rdata_hold", rsp_rdata_o, exp_rdata);
        check_eq("err_hold", {31'h0, rsp_err_o}, {31'h0, exp_err});
    endtask

    initial begin
        // Outputs while in reset.
        #3;
        req_i = 1'b1;
        #1;
        check_eq("rst_gnt", {31'h0, gnt_o}, 32'h0);
        check_eq("rst_valids", {29'h0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o}, 32'h0);
        check_eq("rst_readys", {30'h0, m_axi_bready_o, m_axi_rready_o}, 32'h0);
        check_eq("rst_rsp", {31'h0, rsp_valid_o}, 32'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Zero-wait write, delayed W, delayed SLVERR read, read with req held.
        run_txn(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1'b0);
        run_txn(1'b1, 32'h20, 32'h1111_2222, 4'h3, 0, 3, 1, 2'b00, 32'h0, 1'b0);
        run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 2, 2'b10, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 32'hC, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'hA5A5_0F0F, 1'b1);
        run_txn(1'b1, 32'h30, 32'h5555_AAAA, 4'h9, 2, 0, 0, 2'b11, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset while AW is stalled.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h7777_8888; be_i = 4'hF;
        @(negedge clk_i);
        m_axi_wready_i = 1'b1;
        #1 check_eq("pre_rst_awvalid", {31'h0, m_axi_awvalid_o}, 32'h1);
        @(negedge clk_i);
        m_axi_wready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_awvalid", {31'h0, m_axi_awvalid_o}, 32'h0);
        check_eq("mid_rst_wvalid", {31'h0, m_axi_wvalid_o}, 32'h0);
        check_eq("mid_rst_gnt", {31'h0, gnt_o}, 32'h0);
        check_eq("mid_rst_awaddr", m_axi_awaddr_o, 32'h0);
        check_eq("mid_rst_wdata", m_axi_wdata_o, 32'h0);
        check_eq("mid_rst_rdata", rsp_rdata_o, 32'h0);
        check_eq("mid_rst_err", {31'h0, rsp_err_o}, 32'h0);
        check_eq("mid_rst_bready", {31'h0, m_axi_bready_o}, 32'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check_eq("post_rst_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
            check_eq("post_rst_awvalid", {31'h0, m_axi_awvalid_o}, 32'h0);
        end
        exp_rdata = 32'h0; exp_err = 1'b0;

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
        // B never arrives: watchdog answers, then a late B is drained quietly.
        run_txn(1'b1, 32'h50, 32'h0BAD_CAFE, 4'hF, 0, 0, 1000, 2'b00, 32'h0, 1'b0);
        m_axi_bvalid_i = 1'b1;
        #1 check_eq("drain_bready", {31'h0, m_axi_bready_o}, 32'h1);
        @(negedge clk_i);
        m_axi_bvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("drain_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
            @(negedge clk_i);
        end
        run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h1357_9BDF, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
